// File: rtl/tis_any_writer.sv
// TIS "ANY" port writer: offers one latched value on all four links and hands it
// to the first neighbour that requests it. Optional last-port tracking: TIS_ANY_LAST_EN.
module tis_any_writer #(
    parameter int DATA_WIDTH = 11,
    parameter int LINK_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  wrReq,
    input  logic [DATA_WIDTH-1:0] wrData,
    output logic                  wrDone,
    output logic                  busy,
    output logic [1:0]            lastPort,
    output logic                  lastValid,
    output logic [LINK_WIDTH-1:0] leftOut,
    output logic [LINK_WIDTH-1:0] rightOut,
    output logic [LINK_WIDTH-1:0] upOut,
    output logic [LINK_WIDTH-1:0] downOut,
    input  logic [LINK_WIDTH-1:0] left,
    input  logic [LINK_WIDTH-1:0] right,
    input  logic [LINK_WIDTH-1:0] up,
    input  logic [LINK_WIDTH-1:0] down
);

    localparam int OFFER_BIT = DATA_WIDTH;
    localparam int REQ_BIT   = DATA_WIDTH + 1;
    localparam int GRANT_BIT = DATA_WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_GRANT = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                          state_q, state_d;
    logic [DATA_WIDTH-1:0]           data_q, data_d;
    logic [1:0]                      winner_q, winner_d;
    logic [3:0][LINK_WIDTH-1:0]      links_q, links_d;
    logic                            done_q, done_d;
    logic                            busy_q, busy_d;
    logic                            any_req_s;
    logic [1:0]                      prio_s;
    logic                            unused_s;

    function automatic logic [LINK_WIDTH-1:0] make_link(input logic [DATA_WIDTH-1:0] d,
                                                        input logic offer,
                                                        input logic grant);
        logic [LINK_WIDTH-1:0] w;
        w = {LINK_WIDTH{1'b0}};
        w[DATA_WIDTH-1:0] = d;
        w[OFFER_BIT]      = offer;
        w[GRANT_BIT]      = grant;
        return w;
    endfunction

    // Only the read-request bit of each incoming link carries meaning here.
    assign unused_s  = ^{left, right, up, down};
    assign any_req_s = left[REQ_BIT] | right[REQ_BIT] | up[REQ_BIT] | down[REQ_BIT];

    // Fixed-priority winner select: left > right > up > down.
    always_comb begin
        prio_s = 2'd3;
        if (left[REQ_BIT]) begin
            prio_s = 2'd0;
        end else if (right[REQ_BIT]) begin
            prio_s = 2'd1;
        end else if (up[REQ_BIT]) begin
            prio_s = 2'd2;
        end else begin
            prio_s = 2'd3;
        end
    end

    // Next-state and payload/winner capture.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        winner_d = winner_q;
        case (state_q)
            S_IDLE: begin
                if (wrReq) begin
                    state_d = S_OFFER;
                    data_d  = wrData;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OFFER: begin
                if (any_req_s) begin
                    state_d  = S_GRANT;
                    winner_d = prio_s;
                end else begin
                    state_d = S_OFFER;
                end
            end
            S_GRANT: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered values line up with the state.
    always_comb begin
        links_d = {4*LINK_WIDTH{1'b0}};
        done_d  = 1'b0;
        busy_d  = (state_d != S_IDLE);
        case (state_d)
            S_OFFER: begin
                for (int i = 0; i < 4; i++) begin
                    links_d[i] = make_link(data_d, 1'b1, 1'b0);
                end
            end
            S_GRANT: links_d[winner_d] = make_link(data_d, 1'b1, 1'b1);
            S_DONE:  done_d = 1'b1;
            default: done_d = 1'b0;
        endcase
    end

    // State, payload and output registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= S_IDLE;
            data_q   <= {DATA_WIDTH{1'b0}};
            winner_q <= 2'd0;
            links_q  <= {4*LINK_WIDTH{1'b0}};
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            winner_q <= winner_d;
            links_q  <= links_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign leftOut  = links_q[0];
    assign rightOut = links_q[1];
    assign upOut    = links_q[2];
    assign downOut  = links_q[3];
    assign wrDone   = done_q;
    assign busy     = busy_q;

`ifdef TIS_ANY_LAST_EN
    logic [1:0] last_port_q;
    logic       last_valid_q;

    // Record the consuming port as the write completes.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            last_port_q  <= 2'd0;
            last_valid_q <= 1'b0;
        end else if (state_d == S_DONE) begin
            last_port_q  <= winner_d;
            last_valid_q <= 1'b1;
        end else begin
            last_port_q  <= last_port_q;
            last_valid_q <= last_valid_q;
        end
    end

    assign lastPort  = last_port_q;
    assign lastValid = last_valid_q;
`else
    assign lastPort  = 2'b00;
    assign lastValid = 1'b0;
`endif

endmodule

// File: tb/tb_tis_any_writer.sv
// Directed table-driven bench for tis_any_writer, plus hand-written sequences
// for back-to-back writes and reset abort.
module tb_tis_any_writer;

    logic        clk;
    logic        resetN;
    logic        wrReq;
    logic [10:0] wrData;
    logic        wrDone;
    logic        busy;
    logic [1:0]  lastPort;
    logic        lastValid;
    logic [14:0] leftOut, rightOut, upOut, downOut;
    logic [14:0] left, right, up, down;

    int tests_run = 0;
    int tests_failed = 0;

    tis_any_writer dut (
        .clk      (clk),
        .resetN   (resetN),
        .wrReq    (wrReq),
        .wrData   (wrData),
        .wrDone   (wrDone),
        .busy     (busy),
        .lastPort (lastPort),
        .lastValid(lastValid),
        .leftOut  (leftOut),
        .rightOut (rightOut),
        .upOut    (upOut),
        .downOut  (downOut),
        .left     (left),
        .right    (right),
        .up       (up),
        .down     (down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode: 0 all links zero, 1 offer on all links, 2 grant on link xi only
    typedef struct {
        logic        wr;
        logic [10:0] d;
        logic [3:0]  rq;
        int          mode;
        logic [10:0] xd;
        int          xi;
        logic        xb;
        logic        xdone;
        logic [1:0]  xlp;
        logic        xlv;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [14:0] lw(input logic [10:0] d, input logic g);
        return {1'b0, g, 1'b0, 1'b1, d};
    endfunction

    // Incoming links carry junk data so only bit 12 should matter.
    function automatic logic [14:0] lnk_in(input logic req);
        return {1'b0, 1'b0, req, 1'b0, 11'h2AA};
    endfunction

    function automatic void add(input logic wr, input logic [10:0] d, input logic [3:0] rq,
                                input int mode, input logic [10:0] xd, input int xi,
                                input logic xb, input logic xdone,
                                input logic [1:0] xlp, input logic xlv);
        vec_t v;
        v.wr = wr; v.d = d; v.rq = rq; v.mode = mode; v.xd = xd; v.xi = xi;
        v.xb = xb; v.xdone = xdone; v.xlp = xlp; v.xlv = xlv;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input logic [3:0] rq);
        left  = lnk_in(rq[3]);
        right = lnk_in(rq[2]);
        up    = lnk_in(rq[1]);
        down  = lnk_in(rq[0]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_last(input string nm, input logic [1:0] lp, input logic lv);
        logic [1:0] elp;
        logic       elv;
`ifdef TIS_ANY_LAST_EN
        elp = lp;
        elv = lv;
`else
        elp = 2'b00;
        elv = 1'b0;
`endif
        chk({nm, " lastPort"}, {30'd0, lastPort}, {30'd0, elp});
        chk({nm, " lastValid"}, {31'd0, lastValid}, {31'd0, elv});
    endtask

    initial begin
        logic [14:0] xl[4];
        logic [10:0] val;
        int k;

        resetN = 1'b0;
        wrReq  = 1'b0;
        wrData = 11'd0;
        drive_req(4'b0000);

        // Scenario A: single write, up reader two cycles later
        add(1'b1, 11'd5, 4'b0000, 1, 11'd5, 0, 1'b1, 1'b0, 2'd0, 1'b0);
        add(1'b0, 11'd0, 4'b0000, 1, 11'd5, 0, 1'b1, 1'b0, 2'd0, 1'b0);
        add(1'b0, 11'd0, 4'b0010, 2, 11'd5, 2, 1'b1, 1'b0, 2'd0, 1'b0);
        add(1'b0, 11'd0, 4'b0000, 0, 11'd0, 0, 1'b1, 1'b1, 2'd2, 1'b1);
        add(1'b0, 11'd0, 4'b0000, 0, 11'd0, 0, 1'b0, 1'b0, 2'd2, 1'b1);
        add(1'b0, 11'd0, 4'b1111, 0, 11'd0, 0, 1'b0, 1'b0, 2'd2, 1'b1);
        // Scenario B: left and down together, left wins; requests in GRANT ignored
        add(1'b1, 11'd100, 4'b0000, 1, 11'd100, 0, 1'b1, 1'b0, 2'd2, 1'b1);
        add(1'b0, 11'd0,   4'b1001, 2, 11'd100, 0, 1'b1, 1'b0, 2'd2, 1'b1);
        add(1'b0, 11'd0,   4'b1001, 0, 11'd0,   0, 1'b1, 1'b1, 2'd0, 1'b1);
        add(1'b0, 11'd0,   4'b0000, 0, 11'd0,   0, 1'b0, 1'b0, 2'd0, 1'b1);
        // Scenario C: -7 waits 10 cycles with wrReq/new data ignored, then right reads
        add(1'b1, -11'sd7, 4'b0000, 1, -11'sd7, 0, 1'b1, 1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            add(1'b1, 11'd3, 4'b0000, 1, -11'sd7, 0, 1'b1, 1'b0, 2'd0, 1'b1);
        end
        add(1'b0, 11'd0, 4'b0100, 2, -11'sd7, 1, 1'b1, 1'b0, 2'd0, 1'b1);
        add(1'b0, 11'd0, 4'b1000, 0, 11'd0,   0, 1'b1, 1'b1, 2'd1, 1'b1);
        add(1'b0, 11'd0, 4'b0000, 0, 11'd0,   0, 1'b0, 1'b0, 2'd1, 1'b1);
        // Scenario D: boundary payloads -999 (down) and 999 (up beats down)
        add(1'b1, -11'sd999, 4'b0000, 1, -11'sd999, 0, 1'b1, 1'b0, 2'd1, 1'b1);
        add(1'b0, 11'd0,     4'b0001, 2, -11'sd999, 3, 1'b1, 1'b0, 2'd1, 1'b1);
        add(1'b0, 11'd0,     4'b0000, 0, 11'd0,     0, 1'b1, 1'b1, 2'd3, 1'b1);
        add(1'b0, 11'd0,     4'b0000, 0, 11'd0,     0, 1'b0, 1'b0, 2'd3, 1'b1);
        add(1'b1, 11'd999,   4'b0000, 1, 11'd999,   0, 1'b1, 1'b0, 2'd3, 1'b1);
        add(1'b0, 11'd0,     4'b0011, 2, 11'd999,   2, 1'b1, 1'b0, 2'd3, 1'b1);
        add(1'b0, 11'd0,     4'b0000, 0, 11'd0,     0, 1'b1, 1'b1, 2'd2, 1'b1);
        add(1'b0, 11'd0,     4'b0000, 0, 11'd0,     0, 1'b0, 1'b0, 2'd2, 1'b1);

        // Reset state
        #12;
        chk("rst leftOut",  {17'd0, leftOut},  32'd0);
        chk("rst rightOut", {17'd0, rightOut}, 32'd0);
        chk("rst upOut",    {17'd0, upOut},    32'd0);
        chk("rst downOut",  {17'd0, downOut},  32'd0);
        chk("rst busy",     {31'd0, busy},     32'd0);
        chk("rst wrDone",   {31'd0, wrDone},   32'd0);
        chk_last("rst", 2'd0, 1'b0);
        resetN = 1'b1;

        foreach (tbl[i]) begin
            wrReq  = tbl[i].wr;
            wrData = tbl[i].d;
            drive_req(tbl[i].rq);
            step();
            for (int j = 0; j < 4; j++) begin
                if (tbl[i].mode == 1) begin
                    xl[j] = lw(tbl[i].xd, 1'b0);
                end else if (tbl[i].mode == 2 && tbl[i].xi == j) begin
                    xl[j] = lw(tbl[i].xd, 1'b1);
                end else begin
                    xl[j] = 15'd0;
                end
            end
            chk($sformatf("v%0d leftOut", i),  {17'd0, leftOut},  {17'd0, xl[0]});
            chk($sformatf("v%0d rightOut", i), {17'd0, rightOut}, {17'd0, xl[1]});
            chk($sformatf("v%0d upOut", i),    {17'd0, upOut},    {17'd0, xl[2]});
            chk($sformatf("v%0d downOut", i),  {17'd0, downOut},  {17'd0, xl[3]});
            chk($sformatf("v%0d busy", i),     {31'd0, busy},     {31'd0, tbl[i].xb});
            chk($sformatf("v%0d wrDone", i),   {31'd0, wrDone},   {31'd0, tbl[i].xdone});
            chk_last($sformatf("v%0d", i), tbl[i].xlp, tbl[i].xlv);
        end

        // Back-to-back writes 1,2,3 with wrReq held and down always reading
        wrReq = 1'b1;
        drive_req(4'b0001);
        for (int e = 0; e < 12; e++) begin
            val    = 11'(e / 4 + 1);
            wrData = val;
            step();
            k = e % 4;
            chk($sformatf("b2b e%0d wrDone", e), {31'd0, wrDone}, {31'd0, (k == 2)});
            if (k == 0) begin
                chk($sformatf("b2b e%0d offer", e), {17'd0, leftOut}, {17'd0, lw(val, 1'b0)});
            end else if (k == 1) begin
                chk($sformatf("b2b e%0d grant", e), {17'd0, downOut}, {17'd0, lw(val, 1'b1)});
            end else begin
                chk($sformatf("b2b e%0d busy", e), {31'd0, busy}, {31'd0, (k == 2)});
            end
        end
        wrReq = 1'b0;
        drive_req(4'b0000);
        step();

        // Reset asserted mid-GRANT aborts the write
        wrReq  = 1'b1;
        wrData = 11'd42;
        step();
        wrReq = 1'b0;
        drive_req(4'b0001);
        step();
        chk("abort pre grant", {17'd0, downOut}, {17'd0, lw(11'd42, 1'b1)});
        #2;
        resetN = 1'b0;
        #1;
        chk("abort leftOut",  {17'd0, leftOut},  32'd0);
        chk("abort rightOut", {17'd0, rightOut}, 32'd0);
        chk("abort upOut",    {17'd0, upOut},    32'd0);
        chk("abort downOut",  {17'd0, downOut},  32'd0);
        chk("abort busy",     {31'd0, busy},     32'd0);
        chk("abort wrDone",   {31'd0, wrDone},   32'd0);
        chk_last("abort", 2'd0, 1'b0);
        step();
        resetN = 1'b1;
        drive_req(4'b0000);
        for (int e = 0; e < 4; e++) begin
            step();
            chk($sformatf("post abort e%0d wrDone", e), {31'd0, wrDone}, 32'd0);
            chk($sformatf("post abort e%0d busy", e),   {31'd0, busy},   32'd0);
        end
        chk_last("post abort", 2'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
